// File: rtl/arcade_input_pkg.sv
// Shared types and constants for the arcade input front end: key slots, joystick bit map,
// DIP ioctl index and PS/2 set-2 scancode table.
package arcade_input_pkg;

  typedef enum logic [3:0] {
    K_UP    = 4'd0,
    K_DOWN  = 4'd1,
    K_LEFT  = 4'd2,
    K_RIGHT = 4'd3,
    K_FIRE0 = 4'd4,
    K_FIRE1 = 4'd5,
    K_FIRE2 = 4'd6,
    K_FIRE3 = 4'd7,
    K_START = 4'd8,
    K_COIN  = 4'd9,
    K_TEST  = 4'd10
  } key_slot_e;

  // Per-player slots; K_TEST is global and lives outside the per-player array.
  localparam int unsigned NUM_SLOTS = 10;

  localparam int unsigned JOY_R     = 0;
  localparam int unsigned JOY_L     = 1;
  localparam int unsigned JOY_D     = 2;
  localparam int unsigned JOY_U     = 3;
  localparam int unsigned JOY_FIRE0 = 4;
  localparam int unsigned JOY_START = 8;
  localparam int unsigned JOY_COIN  = 9;

  localparam logic [7:0] DSW_IOCTL_INDEX = 8'd254;

  localparam logic [7:0] SC_P1_UP    = 8'h75;
  localparam logic [7:0] SC_P1_DOWN  = 8'h72;
  localparam logic [7:0] SC_P1_LEFT  = 8'h6B;
  localparam logic [7:0] SC_P1_RIGHT = 8'h74;
  localparam logic [7:0] SC_P1_FIRE0 = 8'h29; // space
  localparam logic [7:0] SC_P1_FIRE1 = 8'h14; // ctrl
  localparam logic [7:0] SC_P1_FIRE2 = 8'h11; // alt
  localparam logic [7:0] SC_P1_FIRE3 = 8'h12; // shift
  localparam logic [7:0] SC_P2_UP    = 8'h2D; // R
  localparam logic [7:0] SC_P2_DOWN  = 8'h2B; // F
  localparam logic [7:0] SC_P2_LEFT  = 8'h23; // D
  localparam logic [7:0] SC_P2_RIGHT = 8'h34; // G
  localparam logic [7:0] SC_P2_FIRE0 = 8'h1C; // A
  localparam logic [7:0] SC_P2_FIRE1 = 8'h1B; // S
  localparam logic [7:0] SC_P2_FIRE2 = 8'h15; // Q
  localparam logic [7:0] SC_P2_FIRE3 = 8'h1D; // W
  localparam logic [7:0] SC_P1_START = 8'h16; // 1
  localparam logic [7:0] SC_F1       = 8'h05;
  localparam logic [7:0] SC_P2_START = 8'h1E; // 2
  localparam logic [7:0] SC_F2       = 8'h06;
  localparam logic [7:0] SC_P1_COIN  = 8'h2E; // 5
  localparam logic [7:0] SC_P2_COIN  = 8'h36; // 6
  localparam logic [7:0] SC_TEST     = 8'h2C; // T

  typedef struct packed {
    logic      hit;
    logic      player;
    key_slot_e slot;
  } key_map_t;

  // Only the low byte is decoded, so E0-extended and plain variants map to the same slot.
  function automatic key_map_t decode_key(input logic [7:0] code);
    key_map_t m;
    m.hit    = 1'b1;
    m.player = 1'b0;
    m.slot   = K_UP;
    case (code)
      SC_P1_UP:            m.slot = K_UP;
      SC_P1_DOWN:          m.slot = K_DOWN;
      SC_P1_LEFT:          m.slot = K_LEFT;
      SC_P1_RIGHT:         m.slot = K_RIGHT;
      SC_P1_FIRE0:         m.slot = K_FIRE0;
      SC_P1_FIRE1:         m.slot = K_FIRE1;
      SC_P1_FIRE2:         m.slot = K_FIRE2;
      SC_P1_FIRE3:         m.slot = K_FIRE3;
      SC_P1_START, SC_F1:  m.slot = K_START;
      SC_P1_COIN:          m.slot = K_COIN;
      SC_P2_UP:            begin m.player = 1'b1; m.slot = K_UP;    end
      SC_P2_DOWN:          begin m.player = 1'b1; m.slot = K_DOWN;  end
      SC_P2_LEFT:          begin m.player = 1'b1; m.slot = K_LEFT;  end
      SC_P2_RIGHT:         begin m.player = 1'b1; m.slot = K_RIGHT; end
      SC_P2_FIRE0:         begin m.player = 1'b1; m.slot = K_FIRE0; end
      SC_P2_FIRE1:         begin m.player = 1'b1; m.slot = K_FIRE1; end
      SC_P2_FIRE2:         begin m.player = 1'b1; m.slot = K_FIRE2; end
      SC_P2_FIRE3:         begin m.player = 1'b1; m.slot = K_FIRE3; end
      SC_P2_START, SC_F2:  begin m.player = 1'b1; m.slot = K_START; end
      SC_P2_COIN:          begin m.player = 1'b1; m.slot = K_COIN;  end
      SC_TEST:             m.slot = K_TEST;
      default:             m.hit = 1'b0;
    endcase
    return m;
  endfunction

  // Fire slots past the configured button count are never written.
  function automatic logic slot_in_range(input int unsigned slot, input int unsigned num_buttons);
    if (slot >= int'(K_FIRE0) && slot <= int'(K_FIRE3)) begin
      return (slot - int'(K_FIRE0)) < num_buttons;
    end
    return slot < NUM_SLOTS;
  endfunction

endpackage

// File: rtl/arcade_coin_shaper.sv
// Coin pulse shaper: a rising edge of the raw coin input starts a fixed-length high pulse;
// edges arriving while the pulse is running are ignored.
module arcade_coin_shaper #(
  parameter int unsigned PULSE_CYCLES = 2400
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic coin_raw_i,
  output logic coin_o
);

  localparam int unsigned CntW = $clog2(PULSE_CYCLES + 1);

  logic            coin_prev_q, coin_prev_d;
  logic [CntW-1:0] cnt_q, cnt_d;

  always_comb begin
    coin_prev_d = coin_raw_i;
    cnt_d       = '0;
    if (cnt_q != '0) begin
      cnt_d = cnt_q - 1'b1;
    end else if (coin_raw_i && !coin_prev_q) begin
      cnt_d = CntW'(PULSE_CYCLES);
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      coin_prev_q <= 1'b0;
      cnt_q       <= '0;
    end else begin
      coin_prev_q <= coin_prev_d;
      cnt_q       <= cnt_d;
    end
  end

  assign coin_o = (cnt_q != '0);

endmodule

// File: rtl/arcade_input_mapper.sv
// Arcade player-input front end: PS/2 key state, joystick merge, opposing-direction cancel,
// coin shaping, DIP latching and core reset. Optional autofire: ARCADE_INPUT_AUTOFIRE_EN.
module arcade_input_mapper
  import arcade_input_pkg::*;
#(
  parameter int unsigned NUM_PLAYERS       = 2,
  parameter int unsigned NUM_BUTTONS       = 2,
  parameter int unsigned NUM_DSW           = 1,
  parameter int unsigned COIN_PULSE_CYCLES = 2400,
  parameter int unsigned MERGE_JOY         = 1,
  parameter int unsigned AUTOFIRE_HALF     = 200000
) (
  input  logic                               clk_sys,
  input  logic                               reset_n,
  input  logic [10:0]                        ps2_key,
  input  logic [16*NUM_PLAYERS-1:0]          joy_i,
  input  logic                               ioctl_download,
  input  logic                               ioctl_wr,
  input  logic [7:0]                         ioctl_index,
  input  logic [24:0]                        ioctl_addr,
  input  logic [7:0]                         ioctl_dout,
  input  logic                               ext_reset,
  input  logic                               autofire_i,
  output logic [4*NUM_PLAYERS-1:0]           dir_o,
  output logic [NUM_BUTTONS*NUM_PLAYERS-1:0] btn_o,
  output logic [NUM_PLAYERS-1:0]             start_o,
  output logic [NUM_PLAYERS-1:0]             coin_o,
  output logic                               test_o,
  output logic [8*NUM_DSW-1:0]               dsw_o,
  output logic                               game_reset
);

  localparam int unsigned NB = NUM_BUTTONS;

  logic                                  toggle_q;
  logic [NUM_PLAYERS-1:0][NUM_SLOTS-1:0] key_q, key_d;
  logic                                  test_key_q, test_key_d;
  key_map_t                              key_map;
  logic                                  key_event;

  logic [NUM_PLAYERS-1:0][15:0]          joy_sel;
  logic [15:0]                           joy_any;

  logic [4*NUM_PLAYERS-1:0]              dir_q, dir_d;
  logic [NB*NUM_PLAYERS-1:0]             btn_q, btn_d, btn_raw;
  logic [NUM_PLAYERS-1:0]                start_q, start_d;
  logic [NUM_PLAYERS-1:0]                coin_raw;
  logic                                  test_q;

  logic [8*NUM_DSW-1:0]                  dsw_q, dsw_d;
  logic                                  dl_q;
  logic                                  init_done_q, init_done_d;
  logic                                  game_reset_q, game_reset_d;

  assign key_map   = decode_key(ps2_key[7:0]);
  assign key_event = (ps2_key[10] != toggle_q);

  always_comb begin
    key_d      = key_q;
    test_key_d = test_key_q;
    if (key_event && key_map.hit) begin
      if (key_map.slot == K_TEST) begin
        test_key_d = ps2_key[9];
      end
      for (int p = 0; p < NUM_PLAYERS; p++) begin
        for (int s = 0; s < NUM_SLOTS; s++) begin
          if (key_map.player == 1'(p) && key_map.slot == 4'(s) && slot_in_range(s, NB)) begin
            key_d[p][s] = ps2_key[9];
          end
        end
      end
    end
  end

  always_comb begin
    joy_any = '0;
    for (int p = 0; p < NUM_PLAYERS; p++) begin
      joy_any = joy_any | joy_i[16*p +: 16];
    end
    for (int p = 0; p < NUM_PLAYERS; p++) begin
      joy_sel[p] = (MERGE_JOY != 0) ? joy_any : joy_i[16*p +: 16];
    end
  end

  // Raw = key | joystick; both directions of an opposing pair drop out when held together.
  always_comb begin
    dir_d    = '0;
    btn_raw  = '0;
    start_d  = '0;
    coin_raw = '0;
    for (int p = 0; p < NUM_PLAYERS; p++) begin
      dir_d[4*p+3] = (key_d[p][K_UP]    | joy_sel[p][JOY_U]) &
                    ~(key_d[p][K_DOWN]  | joy_sel[p][JOY_D]);
      dir_d[4*p+2] = (key_d[p][K_DOWN]  | joy_sel[p][JOY_D]) &
                    ~(key_d[p][K_UP]    | joy_sel[p][JOY_U]);
      dir_d[4*p+1] = (key_d[p][K_LEFT]  | joy_sel[p][JOY_L]) &
                    ~(key_d[p][K_RIGHT] | joy_sel[p][JOY_R]);
      dir_d[4*p+0] = (key_d[p][K_RIGHT] | joy_sel[p][JOY_R]) &
                    ~(key_d[p][K_LEFT]  | joy_sel[p][JOY_L]);
      for (int k = 0; k < NB; k++) begin
        btn_raw[NB*p+k] = key_d[p][int'(K_FIRE0)+k] | joy_sel[p][JOY_FIRE0+k];
      end
      start_d[p]  = key_d[p][K_START] | joy_sel[p][JOY_START];
      coin_raw[p] = key_d[p][K_COIN]  | joy_sel[p][JOY_COIN];
    end
  end

`ifdef ARCADE_INPUT_AUTOFIRE_EN
  localparam int unsigned AfW = $clog2(AUTOFIRE_HALF + 1);

  logic [NUM_PLAYERS-1:0]          af_run_q, af_run_d;
  logic [NUM_PLAYERS-1:0]          af_lvl_q, af_lvl_d;
  logic [NUM_PLAYERS-1:0][AfW-1:0] af_cnt_q, af_cnt_d;

  // af_cnt counts cycles spent at the current level; a fresh press always starts high.
  always_comb begin
    af_run_d = '0;
    af_lvl_d = '0;
    af_cnt_d = '0;
    btn_d    = btn_raw;
    for (int p = 0; p < NUM_PLAYERS; p++) begin
      if (autofire_i && btn_raw[NB*p]) begin
        af_run_d[p] = 1'b1;
        if (!af_run_q[p]) begin
          af_lvl_d[p] = 1'b1;
          af_cnt_d[p] = AfW'(1);
        end else if (af_cnt_q[p] == AfW'(AUTOFIRE_HALF)) begin
          af_lvl_d[p] = ~af_lvl_q[p];
          af_cnt_d[p] = AfW'(1);
        end else begin
          af_lvl_d[p] = af_lvl_q[p];
          af_cnt_d[p] = af_cnt_q[p] + 1'b1;
        end
        btn_d[NB*p] = af_lvl_d[p];
      end
    end
  end

  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) begin
      af_run_q <= '0;
      af_lvl_q <= '0;
      af_cnt_q <= '0;
    end else begin
      af_run_q <= af_run_d;
      af_lvl_q <= af_lvl_d;
      af_cnt_q <= af_cnt_d;
    end
  end
`else
  logic unused_autofire;
  assign unused_autofire = autofire_i;

  always_comb begin
    btn_d = btn_raw;
  end
`endif

  always_comb begin
    dsw_d = dsw_q;
    if (ioctl_wr && ioctl_index == DSW_IOCTL_INDEX) begin
      for (int i = 0; i < NUM_DSW; i++) begin
        if (ioctl_addr == 25'(i)) begin
          dsw_d[8*i +: 8] = ioctl_dout;
        end
      end
    end
  end

  // Only a download that ends while out of reset releases the core.
  always_comb begin
    init_done_d  = init_done_q | (dl_q & ~ioctl_download);
    game_reset_d = ~init_done_q | ext_reset;
  end

  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) begin
      toggle_q     <= 1'b0;
      key_q        <= '0;
      test_key_q   <= 1'b0;
      dir_q        <= '0;
      btn_q        <= '0;
      start_q      <= '0;
      test_q       <= 1'b0;
      dsw_q        <= '0;
      dl_q         <= 1'b0;
      init_done_q  <= 1'b0;
      game_reset_q <= 1'b1;
    end else begin
      toggle_q     <= ps2_key[10];
      key_q        <= key_d;
      test_key_q   <= test_key_d;
      dir_q        <= dir_d;
      btn_q        <= btn_d;
      start_q      <= start_d;
      test_q       <= test_key_d;
      dsw_q        <= dsw_d;
      dl_q         <= ioctl_download;
      init_done_q  <= init_done_d;
      game_reset_q <= game_reset_d;
    end
  end

  for (genvar p = 0; p < NUM_PLAYERS; p++) begin : g_coin
    arcade_coin_shaper #(
      .PULSE_CYCLES (COIN_PULSE_CYCLES)
    ) u_coin_shaper (
      .clk_i      (clk_sys),
      .rst_ni     (reset_n),
      .coin_raw_i (coin_raw[p]),
      .coin_o     (coin_o[p])
    );
  end

  logic unused_bits;
  assign unused_bits = ^{ps2_key[8], joy_i};

  assign dir_o      = dir_q;
  assign btn_o      = btn_q;
  assign start_o    = start_q;
  assign test_o     = test_q;
  assign dsw_o      = dsw_q;
  assign game_reset = game_reset_q;

endmodule

// File: tb/tb_arcade_input_mapper.sv
// Randomised bench for arcade_input_mapper against a behavioural model, plus directed checks
// with literal expectations.
module tb_arcade_input_mapper;

  localparam int NP = 2;
  localparam int NB = 2;
  localparam int ND = 1;
  localparam int CP = 4;
  localparam int MJ = 0;
  localparam int AH = 3;

  logic              clk_sys = 1'b0;
  logic              reset_n;
  logic [10:0]       ps2_key;
  logic [16*NP-1:0]  joy_i;
  logic              ioctl_download, ioctl_wr, ext_reset, autofire_i;
  logic [7:0]        ioctl_index, ioctl_dout;
  logic [24:0]       ioctl_addr;
  logic [4*NP-1:0]   dir_o;
  logic [NB*NP-1:0]  btn_o;
  logic [NP-1:0]     start_o, coin_o;
  logic              test_o, game_reset;
  logic [8*ND-1:0]   dsw_o;

  int total = 0;
  int bad   = 0;
  bit cmp_en = 1'b0;

  arcade_input_mapper #(
    .NUM_PLAYERS       (NP),
    .NUM_BUTTONS       (NB),
    .NUM_DSW           (ND),
    .COIN_PULSE_CYCLES (CP),
    .MERGE_JOY         (MJ),
    .AUTOFIRE_HALF     (AH)
  ) dut (
    .clk_sys        (clk_sys),
    .reset_n        (reset_n),
    .ps2_key        (ps2_key),
    .joy_i          (joy_i),
    .ioctl_download (ioctl_download),
    .ioctl_wr       (ioctl_wr),
    .ioctl_index    (ioctl_index),
    .ioctl_addr     (ioctl_addr),
    .ioctl_dout     (ioctl_dout),
    .ext_reset      (ext_reset),
    .autofire_i     (autofire_i),
    .dir_o          (dir_o),
    .btn_o          (btn_o),
    .start_o        (start_o),
    .coin_o         (coin_o),
    .test_o         (test_o),
    .dsw_o          (dsw_o),
    .game_reset     (game_reset)
  );

  always #5 clk_sys = ~clk_sys;

  // Model state: held keys per player (0 U,1 D,2 L,3 R,4..7 fire,8 start,9 coin), coin timers.
  bit              m_key [NP][10];
  bit              m_test, m_tog, m_init, m_dlp;
  bit              m_coin_prev [NP];
  int              m_coin_left [NP];
  int              m_afn [NP];
  logic [4*NP-1:0]  e_dir;
  logic [NB*NP-1:0] e_btn;
  logic [NP-1:0]    e_start, e_coin;
  logic             e_test, e_gr;
  logic [8*ND-1:0]  e_dsw;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s at %0t: got=%0h want=%0h", nm, $time, act, exp);
    end
  endtask

  function automatic bit lookup(input logic [7:0] c, output int pl, output int sl);
    pl = 0;
    sl = 0;
    lookup = 1'b1;
    case (c)
      8'h75: sl = 0;   8'h72: sl = 1;   8'h6B: sl = 2;   8'h74: sl = 3;
      8'h29: sl = 4;   8'h14: sl = 5;   8'h11: sl = 6;   8'h12: sl = 7;
      8'h16: sl = 8;   8'h05: sl = 8;   8'h2E: sl = 9;   8'h2C: sl = 10;
      8'h2D: begin pl = 1; sl = 0; end
      8'h2B: begin pl = 1; sl = 1; end
      8'h23: begin pl = 1; sl = 2; end
      8'h34: begin pl = 1; sl = 3; end
      8'h1C: begin pl = 1; sl = 4; end
      8'h1B: begin pl = 1; sl = 5; end
      8'h15: begin pl = 1; sl = 6; end
      8'h1D: begin pl = 1; sl = 7; end
      8'h1E: begin pl = 1; sl = 8; end
      8'h06: begin pl = 1; sl = 8; end
      8'h36: begin pl = 1; sl = 9; end
      default: lookup = 1'b0;
    endcase
  endfunction

  task automatic model_reset();
    for (int p = 0; p < NP; p++) begin
      for (int s = 0; s < 10; s++) m_key[p][s] = 1'b0;
      m_coin_prev[p] = 1'b0;
      m_coin_left[p] = 0;
      m_afn[p]       = 0;
    end
    m_test = 0; m_tog = 0; m_init = 0; m_dlp = 0;
    e_dir = '0; e_btn = '0; e_start = '0; e_coin = '0; e_test = 0; e_dsw = '0; e_gr = 1'b1;
  endtask

  task automatic model_step();
    int pl, sl;
    logic [15:0] j;
    bit u, d, l, r, c;
    if (ps2_key[10] != m_tog && lookup(ps2_key[7:0], pl, sl)) begin
      if (sl == 10) m_test = ps2_key[9];
      else m_key[pl][sl] = ps2_key[9];
    end
    m_tog = ps2_key[10];
    e_test = m_test;
    for (int p = 0; p < NP; p++) begin
      j = (MJ != 0) ? (joy_i[15:0] | joy_i[31:16]) : joy_i[16*p +: 16];
      u = m_key[p][0] | j[3];
      d = m_key[p][1] | j[2];
      l = m_key[p][2] | j[1];
      r = m_key[p][3] | j[0];
      e_dir[4*p +: 4] = {u & !d, d & !u, l & !r, r & !l};
      for (int k = 0; k < NB; k++) e_btn[NB*p+k] = m_key[p][4+k] | j[4+k];
`ifdef ARCADE_INPUT_AUTOFIRE_EN
      if (autofire_i && e_btn[NB*p]) begin
        m_afn[p]++;
        e_btn[NB*p] = (((m_afn[p] - 1) / AH) % 2) == 0;
      end else begin
        m_afn[p] = 0;
      end
`endif
      e_start[p] = m_key[p][8] | j[8];
      c = m_key[p][9] | j[9];
      if (m_coin_left[p] > 0) m_coin_left[p]--;
      else if (c && !m_coin_prev[p]) m_coin_left[p] = CP;
      m_coin_prev[p] = c;
      e_coin[p] = m_coin_left[p] > 0;
    end
    if (ioctl_wr && ioctl_index == 8'd254 && ioctl_addr < ND) e_dsw[8*ioctl_addr[2:0] +: 8] = ioctl_dout;
    e_gr = !m_init || ext_reset;
    if (m_dlp && !ioctl_download) m_init = 1'b1;
    m_dlp = ioctl_download;
  endtask

  initial begin
    model_reset();
    forever begin
      @(posedge clk_sys);
      if (!reset_n) model_reset();
      else model_step();
    end
  end

  initial begin
    forever begin
      @(negedge clk_sys);
      if (cmp_en) begin
        chk("dir", 32'(dir_o), 32'(e_dir));
        chk("btn", 32'(btn_o), 32'(e_btn));
        chk("start", 32'(start_o), 32'(e_start));
        chk("coin", 32'(coin_o), 32'(e_coin));
        chk("test", 32'(test_o), 32'(e_test));
        chk("dsw", 32'(dsw_o), 32'(e_dsw));
        chk("game_reset", 32'(game_reset), 32'(e_gr));
      end
    end
  end

  task automatic tick();
    @(negedge clk_sys);
    #1;
  endtask

  task automatic key(input logic pressed, input logic [8:0] code);
    ps2_key = {~ps2_key[10], pressed, code};
  endtask

  initial begin
    int hi, rises;
    logic prev;
    logic [7:0] pool [12];
    pool = '{8'h75, 8'h72, 8'h6B, 8'h74, 8'h29, 8'h14, 8'h11, 8'h2E, 8'h36, 8'h1C, 8'h2C, 8'h44};

    reset_n = 0; ps2_key = '0; joy_i = '0; ioctl_download = 0; ioctl_wr = 0;
    ioctl_index = 0; ioctl_addr = '0; ioctl_dout = 0; ext_reset = 0; autofire_i = 0;
    tick(); tick();
    chk("reset_dir", 32'(dir_o), 0);
    chk("reset_game_reset", 32'(game_reset), 1);
    chk("reset_dsw", 32'(dsw_o), 0);
    reset_n = 1;
    cmp_en  = 1;
    tick();

    // Key event on up (plain 075 matches the arrow slot)
    key(1, 9'h075); tick();
    chk("key_up_press", 32'(dir_o[3]), 1);
    key(0, 9'h075); tick();
    chk("key_up_release", 32'(dir_o[3]), 0);
    ps2_key[9] = 1'b1; tick();
    chk("key_no_toggle", 32'(dir_o[3]), 0);

    // Opposing cancel
    joy_i = 32'h0000_0003; tick();
    chk("joy_lr_cancel", 32'(dir_o[1:0]), 0);
    joy_i = 32'h0000_0009; tick();
    chk("joy_up_right", 32'(dir_o[3:0]), 32'b1001);
    joy_i = '0; tick();

    // Fire button past NUM_BUTTONS is ignored; fire1 works
    key(1, 9'h011); tick();
    key(1, 9'h014); tick();
    chk("btn_fire1_only", 32'(btn_o), 32'b0010);
    key(0, 9'h014); tick();

    // Coin: one pulse of CP cycles per press
    key(1, 9'h02E);
    hi = 0; rises = 0; prev = 0;
    for (int i = 0; i < 20; i++) begin
      tick();
      if (coin_o[0]) hi++;
      if (coin_o[0] && !prev) rises++;
      prev = coin_o[0];
    end
    chk("coin_high_cycles", hi, CP);
    chk("coin_single_pulse", rises, 1);
    key(0, 9'h02E); tick(); tick();
    key(1, 9'h02E);
    hi = 0;
    for (int i = 0; i < 10; i++) begin
      tick();
      if (coin_o[0]) hi++;
    end
    chk("coin_second_pulse", hi, CP);
    key(0, 9'h02E); tick();

    // DIP latch
    ioctl_wr = 1; ioctl_index = 8'd254; ioctl_addr = 0; ioctl_dout = 8'hA5; tick();
    ioctl_addr = 1; ioctl_dout = 8'h3C; tick();
    ioctl_index = 8'd0; ioctl_addr = 0; ioctl_dout = 8'hFF; tick();
    ioctl_wr = 0; tick();
    chk("dsw_latch", 32'(dsw_o), 32'hA5);

    // Core reset release and ext_reset
    chk("game_reset_before_dl", 32'(game_reset), 1);
    ioctl_download = 1; tick(); tick();
    ioctl_download = 0; tick(); tick();
    chk("game_reset_after_dl", 32'(game_reset), 0);
    ext_reset = 1; tick();
    chk("ext_reset_assert", 32'(game_reset), 1);
    ext_reset = 0; tick();
    chk("ext_reset_release", 32'(game_reset), 0);
    chk("dsw_kept_ext_reset", 32'(dsw_o), 32'hA5);

    // Autofire on P1 fire0
    autofire_i = 1; key(1, 9'h029);
    for (int i = 0; i < 12; i++) begin
      tick();
`ifdef ARCADE_INPUT_AUTOFIRE_EN
      chk("autofire_pattern", 32'(btn_o[0]), ((i / AH) % 2 == 0) ? 1 : 0);
`else
      chk("fire0_steady", 32'(btn_o[0]), 1);
`endif
    end
    key(0, 9'h029); tick();
    chk("fire0_release", 32'(btn_o[0]), 0);
    autofire_i = 0;

    // Reset during a download loses the falling edge
    ioctl_download = 1; tick();
    reset_n = 0; tick();
    ioctl_download = 0; tick();
    reset_n = 1; tick(); tick(); tick();
    chk("reset_mid_dl_held", 32'(game_reset), 1);
    chk("reset_mid_dl_dsw", 32'(dsw_o), 0);
    ioctl_download = 1; tick();
    ioctl_download = 0; tick(); tick();
    chk("reset_mid_dl_release", 32'(game_reset), 0);

    // Random traffic against the model
    for (int c = 0; c < 4000; c++) begin
      if ($urandom_range(0, 99) < 25) begin
        ps2_key = {~ps2_key[10], 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                   pool[$urandom_range(0, 11)]};
      end
      if ($urandom_range(0, 3) == 0) begin
        if ($urandom_range(0, 1) == 0) joy_i[15:0] = 16'($urandom & $urandom & $urandom);
        else joy_i[31:16] = 16'($urandom & $urandom & $urandom);
      end
      ioctl_wr    = ($urandom_range(0, 7) == 0);
      ioctl_index = ($urandom_range(0, 1) == 0) ? 8'd254 : 8'($urandom);
      case ($urandom_range(0, 3))
        0: ioctl_addr = 25'd0;
        1: ioctl_addr = 25'd1;
        2: ioctl_addr = 25'd2;
        default: ioctl_addr = 25'h100_0000;
      endcase
      ioctl_dout = 8'($urandom);
      if ($urandom_range(0, 199) == 0) ioctl_download = ~ioctl_download;
      ext_reset = ($urandom_range(0, 49) == 0);
      if ($urandom_range(0, 99) == 0) autofire_i = ~autofire_i;
      reset_n = !(c >= 2000 && c < 2003);
      tick();
    end

    cmp_en = 0;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
